// File: rtl/draw_pkg.sv
// Shared drawing constants for the board renderer.
// Holds the screen geometry, the cell interior origin tables, the grid line
// coordinates, the 3-bit colour codes, the 2-bit cell-state encoding, and the
// renderer FSM state type. No ports: this is a package.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Top-left corner of each cell interior, by column (x) and by row (y)
  localparam logic [7:0] CELL_X0 = 8'd24;
  localparam logic [7:0] CELL_X1 = 8'd62;
  localparam logic [7:0] CELL_X2 = 8'd100;
  localparam logic [6:0] CELL_Y0 = 7'd4;
  localparam logic [6:0] CELL_Y1 = 7'd42;
  localparam logic [6:0] CELL_Y2 = 7'd80;

  // Grid line positions drawn by the external grid drawer
  localparam logic [7:0] GRID_VX0 = 8'd60;
  localparam logic [7:0] GRID_VX1 = 8'd98;
  localparam logic [6:0] GRID_HY0 = 7'd40;
  localparam logic [6:0] GRID_HY1 = 7'd78;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLUE  = 3'b001;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10,
    CELL_NONE  = 2'b11
  } cell_state_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GRID,
    MARKS,
    FINISH
  } render_state_t;

  // Cells are row-major: col = idx % 3, row = idx / 3
  function automatic logic [7:0] cell_origin_x(input logic [3:0] idx);
    logic [3:0] col;
    col = idx % 4'd3;
    case (col)
      4'd0:    return CELL_X0;
      4'd1:    return CELL_X1;
      default: return CELL_X2;
    endcase
  endfunction

  function automatic logic [6:0] cell_origin_y(input logic [3:0] idx);
    logic [3:0] row;
    row = idx / 4'd3;
    case (row)
      4'd0:    return CELL_Y0;
      4'd1:    return CELL_Y1;
      default: return CELL_Y2;
    endcase
  endfunction

endpackage

// File: rtl/rect_sweep.sv
// Generic rectangle raster counter.
// A start pulse latches the rectangle (x0, y0, w, h); from the next cycle the
// counter walks x fastest then y, one pixel per cycle, with valid high.
// Ports: clk, reset (sync, active-high), start, x0/y0 origin, w/h size
// (both >= 1); outputs x, y current pixel, valid, last (final pixel).
module rect_sweep
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       valid,
  output logic       last
);

  logic [7:0] x_first;
  logic [7:0] x_end;
  logic [6:0] y_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (start) begin
      valid <= 1'b1;
    end else if (last) begin
      valid <= 1'b0;
    end
  end

  // Coordinates are held as data; valid alone qualifies them
  always_ff @(posedge clk) begin
    if (start) begin
      x       <= x0;
      y       <= y0;
      x_first <= x0;
      x_end   <= x0 + w - 8'd1;
      y_end   <= y0 + h - 7'd1;
    end else if (valid) begin
      if (x == x_end) begin
        x <= x_first;
        if (y != y_end) y <= y + 7'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  assign last = valid && (x == x_end) && (y == y_end);

endmodule

// File: rtl/board_renderer.sv
// Tic-tac-toe board renderer.
// On a start request it clears the screen to black, hands the pixel port to
// an external grid drawer until that drawer exits, then draws a square marker
// in every occupied cell (red for player 1, blue for player 2).
// Ports: clk, reset (sync, active-high), start, board[17:0] (2 bits per cell),
// grid_enable/grid_exit handshake and grid_x/y/colour/write pixel input,
// x_out/y_out/colour_out/write_out pixel output, busy, done (1-cycle pulse).
module board_renderer
  import draw_pkg::*;
#(
  parameter int MARK_SIZE  = 24,
  parameter int MARK_INSET = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] board,
  output logic        grid_enable,
  input  logic        grid_exit,
  input  logic [7:0]  grid_x,
  input  logic [6:0]  grid_y,
  input  logic [2:0]  grid_colour,
  input  logic        grid_write,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour_out,
  output logic        write_out,
  output logic        busy,
  output logic        done
);

  render_state_t state_q, state_d;
  logic [17:0]   board_q;
  logic [3:0]    cell_q, cell_d;
  logic          drawing_q, drawing_d;
  logic          latch;

  logic          sw_start, sw_valid, sw_last;
  logic [7:0]    sw_x0, sw_x, sw_w;
  logic [6:0]    sw_y0, sw_y, sw_h;

  logic [19:0]   board_pad;
  cell_state_t   cell_st;
  logic          occupied;
  logic [2:0]    mark_colour;

  // Padding lets index 9 (the flush step) read as an empty cell
  assign board_pad = {2'b00, board_q};
  assign cell_st   = cell_state_t'(board_pad[{cell_q, 1'b0} +: 2]);
  assign occupied  = (cell_st == CELL_P1) || (cell_st == CELL_P2);
  assign mark_colour = (cell_st == CELL_P1) ? RED : BLUE;

  rect_sweep u_sweep (
    .clk   (clk),
    .reset (reset),
    .start (sw_start),
    .x0    (sw_x0),
    .y0    (sw_y0),
    .w     (sw_w),
    .h     (sw_h),
    .x     (sw_x),
    .y     (sw_y),
    .valid (sw_valid),
    .last  (sw_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      board_q   <= '0;
      cell_q    <= '0;
      drawing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      drawing_q <= drawing_d;
      if (latch) board_q <= board;
    end
  end

  always_comb begin
    state_d   = state_q;
    cell_d    = cell_q;
    drawing_d = drawing_q;
    latch     = 1'b0;
    sw_start  = 1'b0;
    sw_x0     = 8'd0;
    sw_y0     = 7'd0;
    sw_w      = 8'(SCREEN_W);
    sw_h      = 7'(SCREEN_H);
    case (state_q)
      IDLE: begin
        if (start) begin
          latch    = 1'b1;
          sw_start = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (sw_last) state_d = GRID;
      end
      GRID: begin
        if (grid_exit) begin
          state_d   = MARKS;
          cell_d    = 4'd0;
          drawing_d = 1'b0;
        end
      end
      MARKS: begin
        sw_x0 = cell_origin_x(cell_q) + 8'(MARK_INSET);
        sw_y0 = cell_origin_y(cell_q) + 7'(MARK_INSET);
        sw_w  = 8'(MARK_SIZE);
        sw_h  = 7'(MARK_SIZE);
        // Index 9 is only reached after a marker in cell 8; it gives the
        // output register one cycle to flush that marker's last pixel
        if (cell_q == 4'd9) begin
          state_d = FINISH;
        end else if (drawing_q) begin
          if (sw_last) begin
            drawing_d = 1'b0;
            cell_d    = cell_q + 4'd1;
          end
        end else if (occupied) begin
          sw_start  = 1'b1;
          drawing_d = 1'b1;
        end else if (cell_q == 4'd8) begin
          state_d = FINISH;
        end else begin
          cell_d = cell_q + 4'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output pixel register: one cycle behind the sweep or the grid drawer
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour_out <= BLACK;
      write_out  <= 1'b0;
    end else begin
      case (state_q)
        CLEAR, MARKS: begin
          write_out <= sw_valid;
          if (sw_valid) begin
            x_out      <= sw_x;
            y_out      <= sw_y;
            colour_out <= (state_q == CLEAR) ? BLACK : mark_colour;
          end
        end
        GRID: begin
          x_out      <= grid_x;
          y_out      <= grid_y;
          colour_out <= grid_colour;
          write_out  <= grid_write;
        end
        default: begin
          write_out <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign grid_enable = (state_q == GRID);

endmodule
